// File: rtl/mc_core_pkg.sv
// Shared encodings for the parametrised multicycle core: FSM states, opcodes
// and ALU operation selects.
package mc_core_pkg;

    localparam int unsigned DW_DEFAULT   = 8;
    localparam int unsigned AW_DEFAULT   = 8;
    localparam int unsigned NREG_DEFAULT = 4;
    localparam int unsigned IW           = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_NAND = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SHL  = 3'd4
    } alu_op_e;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // ORI and SHIFT decode on the low three bits only
    localparam logic [2:0] OP3_SHIFT = 3'b011;
    localparam logic [2:0] OP3_ORI   = 3'b111;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
               (op[2:0] == OP3_ORI) || (op[2:0] == OP3_SHIFT);
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: result plus negative/zero indications for the flag update.
module mc_alu
    import mc_core_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  alu_op_e       op,
    output logic [DW-1:0] out,
    output logic          n,
    output logic          z
);

    always_comb begin
        out = '0;
        unique case (op)
            ALU_ADD:  out = in1 + in2;
            ALU_SUB:  out = in1 - in2;
            ALU_NAND: out = ~(in1 & in2);
            ALU_OR:   out = in1 | in2;
            ALU_SHL:  out = in1 << in2;
            default:  out = '0;
        endcase
    end

    assign n = out[DW-1];
    assign z = (out == '0);

endmodule

// File: rtl/mc_core_param.sv
// Parametrised multicycle core with req/ack memory port, HALT and run/step
// debug control. Register file, IR, PC and FSM live here; arithmetic in mc_alu.
module mc_core_param
    import mc_core_pkg::*;
#(
    parameter int unsigned DW   = DW_DEFAULT,
    parameter int unsigned AW   = AW_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          step,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] pc,
    output logic [2:0]    state,
    output logic          flag_n,
    output logic          flag_z,
    output logic          halted,
    output logic          retire,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [DW-1:0] alu_out_q, alu_out_d;
    logic [DW-1:0] r_q [NREG];
    logic [DW-1:0] r_d [NREG];
    logic          flag_n_q, flag_n_d, flag_z_q, flag_z_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          halted_q, halted_d, retire_q, retire_d;

    logic [DW-1:0] alu_in1_c, alu_in2_c, alu_res_c;
    alu_op_e       alu_op_c;
    logic          alu_n_c, alu_z_c;
    logic [1:0]    dest_c;
    logic [AW-1:0] br_off_c;
    logic          br_taken_c;
    logic          done_c;
    logic          xfer_c;

    // ORI always targets r1 with a zero-extended 5-bit immediate; SHIFT uses a 3-bit amount
    always_comb begin
        alu_in1_c = a_q;
        alu_in2_c = b_q;
        alu_op_c  = ALU_ADD;
        if (ir_q[2:0] == OP3_ORI) begin
            alu_in1_c = r_q[1];
            alu_in2_c = DW'(ir_q[7:3]);
            alu_op_c  = ALU_OR;
        end else if (ir_q[2:0] == OP3_SHIFT) begin
            alu_in2_c = DW'(ir_q[5:3]);
            alu_op_c  = ALU_SHL;
        end else if (ir_q[3:0] == OP_SUB) begin
            alu_op_c = ALU_SUB;
        end else if (ir_q[3:0] == OP_NAND) begin
            alu_op_c = ALU_NAND;
        end
    end

    mc_alu #(.DW(DW)) u_alu (
        .in1 (alu_in1_c),
        .in2 (alu_in2_c),
        .op  (alu_op_c),
        .out (alu_res_c),
        .n   (alu_n_c),
        .z   (alu_z_c)
    );

    assign dest_c   = (ir_q[2:0] == OP3_ORI) ? 2'd1 : ir_q[7:6];
    assign br_off_c = AW'($signed(ir_q[7:4]));
    assign xfer_c   = mem_req_q && mem_ack;

    always_comb begin
        unique case (ir_q[3:0])
            OP_BZ:   br_taken_c = flag_z_q;
            OP_BNZ:  br_taken_c = !flag_z_q;
            OP_BPZ:  br_taken_c = !flag_n_q;
            default: br_taken_c = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_out_d   = alu_out_q;
        r_d         = r_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        retire_d    = 1'b0;
        done_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run || step) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end
            end
            ST_FETCH: begin
                if (xfer_c) begin
                    ir_d      = mem_rdata[IW-1:0];
                    mem_req_d = 1'b0;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                pc_d    = pc_q + AW'(1);
                a_d     = r_q[ir_q[7:6]];
                b_d     = r_q[ir_q[5:4]];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_alu_op(ir_q[3:0])) begin
                    alu_out_d = alu_res_c;
                    flag_n_d  = alu_n_c;
                    flag_z_d  = alu_z_c;
                    state_d   = ST_WB;
                end else if (ir_q[3:0] == OP_LOAD || ir_q[3:0] == OP_STORE) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (ir_q[3:0] == OP_STORE);
                    mem_addr_d  = b_q[AW-1:0];
                    mem_wdata_d = a_q;
                    state_d     = ST_MEM;
                end else if (ir_q[3:0] == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    if (br_taken_c) begin
                        pc_d = pc_q + br_off_c;
                    end
                    done_c = 1'b1;
                end
            end
            ST_MEM: begin
                if (xfer_c) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_we_q) begin
                        done_c = 1'b1;
                    end else begin
                        alu_out_d = mem_rdata;
                        state_d   = ST_WB;
                    end
                end
            end
            ST_WB: begin
                r_d[dest_c] = alu_out_q;
                done_c      = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retirement: the next fetch launches at once when free-running
        if (done_c) begin
            retire_d = 1'b1;
            if (run) begin
                state_d    = ST_FETCH;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_d;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                r_q[i] <= '0;
            end
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            r_q         <= r_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            retire_q    <= retire_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign halted    = halted_q;
    assign retire    = retire_q;
    assign dbg_data  = r_q[dbg_sel];

endmodule

// File: doc/mc_core_param.md
Name: mc_core_param

Overview:
Parametrised next-generation multicycle core. It runs the team's 8-bit-encoded ISA (load, store, add, sub, nand, ori, shift, bz, bnz, bpz) over a DW-bit datapath and an AW-bit address space. It adds three things: a variable-latency req/ack memory port, a HALT instruction, and run/single-step debug control. It sits between the board top level (keys, HEX, LEDs) and an external memory wrapper.

Parameters:
DW, 8, data/register width (≥8); instruction = low 8 bits of fetched word, upper bits ignored
AW, 8, address/PC width (≤DW)
NREG, 4, register count; fixed at 4 (2-bit fields); present for package consistency only

Ports:
clock  in  1  system clock, rising edge
reset  in  1  reset, asynchronous, active-high
run  in  1  1 = free-run; 0 = stop at instruction boundary
step  in  1  in IDLE, 1 = execute exactly one instruction
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  AW  request address
mem_wdata  out  DW  write data
mem_ack  in  1  transfer complete; rdata valid this cycle
mem_rdata  in  DW  read data
pc  out  AW  current PC
state  out  3  FSM state code
flag_n, flag_z  out  1  condition flags
halted  out  1  core in HALT
retire  out  1  one-cycle pulse per completed instruction
dbg_sel  in  2  register select for dbg_data
dbg_data  out  DW  combinational read of r[dbg_sel]

Behaviour:
- Reset (async): PC=0, IR=0, r0..r3=0, N=Z=0, state=IDLE, mem_req=0, mem_we=0, retire=0, halted=0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: if run|step → FETCH, else stay.
- FETCH: mem_req=1, we=0, addr=PC. On ack: IR<=rdata[7:0] → DECODE.
- DECODE: PC<=PC+1 (mod 2^AW). Latch A=r[IR[7:6]], B=r[IR[5:4]].
- EXEC:
  - ALU ops compute into ALUOut and update N,Z → WB.
  - LOAD/STORE → MEM.
  - Branches: if taken, PC<=PC+sext(IR[7:4]) (PC already incremented; wrap mod 2^AW); then retire.
  - HALT → HALT.
  - Undefined opcode: NOP, retire.
- MEM: mem_req=1, addr=B[AW-1:0].
  - STORE: we=1, wdata=A; on ack retire.
  - LOAD: we=0; on ack ALUOut<=rdata → WB.
- WB: r[dest]<=ALUOut; retire.
- Retire: retire=1 for one cycle; next state FETCH if run, else IDLE.
- Opcodes (IR[3:0]):
  - LOAD 0000: rx<=M[ry].
  - STORE 0010: M[ry]<=rx.
  - ADD 0100, SUB 0110 (rx-ry), NAND 1000: rx<=rx op ry.
  - ORI x111: r1<=r1 | zext(IR[7:3]).
  - SHIFT x011: rx<=rx << IR[5:3], logical, zero fill.
  - BZ 0101 (Z=1), BNZ 1001 (Z=0), BPZ 1101 (N=0).
  - HALT 0001.
- Flags: Z=(result==0), N=result[DW-1]. Written only by ADD/SUB/NAND/ORI/SHIFT. Arithmetic wraps mod 2^DW; no carry or overflow flag.
- Handshake:
  - One outstanding transfer.
  - addr/we/wdata stable while req=1 and ack=0.
  - ack in the first req cycle allowed (zero wait).
  - ack while req=0 ignored.
- Latency at zero wait state: ALU 4 cycles; LOAD 5; STORE 4; branch/NOP 3 (FETCH→retire inclusive).
- HALT: halted=1, mem_req=0, no further state change until reset; run/step ignored.
- run drop mid-instruction: current instruction completes, then IDLE.
- step held high: one instruction per pass through IDLE.
- Reset mid-transfer: mem_req deasserts asynchronously; memory wrapper must tolerate abandoned transfers.

Decomposition:
- Package mc_core_pkg: opcode constants, state encodings, ALU op codes (ADD, SUB, NAND, OR, SHL).
- Sub-module mc_alu (parameter DW): in1, in2, op → out, n, z; purely combinational.
- Register file, IR, PC and FSM inline in mc_core_param.

Test Plan:
- Reset, run=1, memory[0]=0x01 (HALT), zero wait → FETCH@1, DECODE@2, EXEC@3, halted=1 from cycle 4; pc=1; retire never pulses.
- Program `ORI 5`; `ADD r1,r1`; HALT, zero wait → r1=0x0A, N=0, Z=0; ADD retires exactly 4 cycles after ORI retires.
- LOAD r0,[r1] with r1=0x20, M[0x20]=0x80, ack delayed 3 cycles → mem_addr=0x20 stable across all wait cycles; r0=0x80; N=0 (LOAD doesn't touch flags).
- SUB r2,r2 → Z=1; then BZ imm=0xE (−2) at pc=5 → pc=4 after EXEC; the same branch with Z=0 → pc=6.
- run=0 after reset; one-cycle step pulses → exactly one retire per pulse; state returns to IDLE; no mem_req while in IDLE.
- DW=16, AW=8: `ORI 0x1F`; `SHIFT r1,7`; HALT → r1=0x0F80, N=0; SHIFT by 7 again → 0xC000, N=1.
